// File: rtl/led_blink_pkg.sv
// Shared definitions for the multi-channel LED blinker.
//   MODE_*     : 2-bit per-channel mode encodings.
//   ch_state_e : per-channel FSM state.
package led_blink_pkg;

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_SOLID = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;
   localparam logic [1:0] MODE_BURST = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOLID,
      ST_ON,
      ST_OFF,
      ST_GAP
   } ch_state_e;

endpackage

// File: rtl/led_blink_ch.sv
// One LED channel: mode FSM, phase counter, burst pulse counter, output regs.
//   clk500hz    : system clock, rising edge
//   rst         : synchronous active-high reset
//   en          : channel enable
//   mode        : OFF / SOLID / BLINK / BURST
//   half_period : half-period H in cycles (0 behaves as 1)
//   led         : registered LED drive
//   done        : one-cycle pulse when the burst gap is entered
module led_blink_ch
   import led_blink_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int BURST_N    = 3,
   parameter int GAP_HALVES = 4
) (
   input  logic             clk500hz,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] half_period,
   output logic             led,
   output logic             done
);

   // Three extra bits hold GAP_HALVES*H without wrapping.
   localparam int CW = CNT_W + 3;
   localparam int PW = $clog2(BURST_N + 1);

   ch_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   pcnt_q, pcnt_d;
   logic            en_q;
   logic [1:0]      mode_q;
   logic            led_q, done_q, done_d;

   logic [CW-1:0]   h_ext, ph_lim, gap_lim;
   logic            restart;

   assign h_ext   = (half_period == '0) ? CW'(1) : {3'b000, half_period};
   assign ph_lim  = h_ext - CW'(1);
   assign gap_lim = CW'(GAP_HALVES) * h_ext - CW'(1);

   // Entering a timed mode from disabled or from a different mode restarts
   // the waveform; this also covers BLINK<->BURST switches.
   assign restart = en && mode[1] && (!en_q || (mode_q != mode));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pcnt_d  = pcnt_q;
      done_d  = 1'b0;
      if (!en || mode == MODE_OFF) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         pcnt_d  = '0;
      end else if (mode == MODE_SOLID) begin
         state_d = ST_SOLID;
         cnt_d   = '0;
         pcnt_d  = '0;
      end else if (restart) begin
         state_d = ST_ON;
         cnt_d   = '0;
         pcnt_d  = '0;
      end else begin
         // '>=' lets a shrunk H end the running phase on the next edge.
         unique case (state_q)
            ST_ON: begin
               if (cnt_q >= ph_lim) begin
                  cnt_d   = '0;
                  state_d = ST_OFF;
                  if (mode == MODE_BURST) begin
                     pcnt_d = pcnt_q + PW'(1);
                     if (pcnt_q + PW'(1) == PW'(BURST_N)) begin
                        state_d = ST_GAP;
                        done_d  = 1'b1;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_OFF: begin
               if (cnt_q >= ph_lim) begin
                  cnt_d   = '0;
                  state_d = ST_ON;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_GAP: begin
               if (cnt_q >= gap_lim) begin
                  cnt_d   = '0;
                  pcnt_d  = '0;
                  state_d = ST_ON;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               // IDLE/SOLID with a timed mode always passes through restart;
               // fall back to a clean ON phase just in case.
               state_d = ST_ON;
               cnt_d   = '0;
               pcnt_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk500hz) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pcnt_q  <= '0;
         en_q    <= 1'b0;
         mode_q  <= MODE_OFF;
         led_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pcnt_q  <= pcnt_d;
         en_q    <= en;
         mode_q  <= mode;
         led_q   <= (state_d == ST_ON) || (state_d == ST_SOLID);
         done_q  <= done_d;
      end
   end

   assign led  = led_q;
   assign done = done_q;

endmodule

// File: rtl/led_blinker_multi.sv
// N_CH independent LED channels driven from the 500 Hz tick.
//   clk500hz    : system clock, rising edge
//   rst         : synchronous active-high reset
//   LED_on      : per-channel enable
//   mode        : per-channel mode, bits [2i+1:2i]
//   half_period : per-channel H, bits [CNT_W*(i+1)-1:CNT_W*i]
//   LED_blink   : registered LED drives
//   burst_done  : per-channel burst-complete pulse
module led_blinker_multi
   import led_blink_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int CNT_W      = 8,
   parameter int BURST_N    = 3,
   parameter int GAP_HALVES = 4
) (
   input  logic                  clk500hz,
   input  logic                  rst,
   input  logic [N_CH-1:0]       LED_on,
   input  logic [2*N_CH-1:0]     mode,
   input  logic [CNT_W*N_CH-1:0] half_period,
   output logic [N_CH-1:0]       LED_blink,
   output logic [N_CH-1:0]       burst_done
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      led_blink_ch #(
         .CNT_W      (CNT_W),
         .BURST_N    (BURST_N),
         .GAP_HALVES (GAP_HALVES)
      ) u_ch (
         .clk500hz    (clk500hz),
         .rst         (rst),
         .en          (LED_on[g]),
         .mode        (mode[2*g +: 2]),
         .half_period (half_period[CNT_W*g +: CNT_W]),
         .led         (LED_blink[g]),
         .done        (burst_done[g])
      );
   end

endmodule
